// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: data width, the canonical NOP and the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/imem_rom.sv
// Combinational instruction ROM. The image is supplied as a packed parameter, word 0 in the LSBs.
// Addresses beyond the populated depth read as NOP and report in_range=0.
module imem_rom
  import riscv_pkg::*;
#(
  parameter int                         IMEM_WORDS = 256,
  parameter logic [XLEN*IMEM_WORDS-1:0] IMEM_INIT  = {IMEM_WORDS{RV_NOP}}
) (
  input  logic [XLEN-3:0] word_addr,
  output logic [XLEN-1:0] rdata,
  output logic            in_range
);

  localparam int AW = $clog2(IMEM_WORDS);

  logic [AW-1:0] idx;

  assign idx = word_addr[AW-1:0];

  always_comb begin
    in_range = (word_addr[XLEN-3:AW] == '0);
    rdata    = RV_NOP;
    if (in_range) begin
      rdata = IMEM_INIT[{idx, 5'd0} +: XLEN];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, fetch FSM and the IF/DE pipeline register feeding decode.
// Optional macro MISALIGN_TRAP_EN turns a misaligned redirect into a faulting slot and a halt.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                         IMEM_WORDS = 256,
  parameter logic [XLEN-1:0]            RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN*IMEM_WORDS-1:0] IMEM_INIT  = {IMEM_WORDS{RV_NOP}}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_if,
  input  logic        flush_de,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc_if,
  output logic [31:0] inst_de,
  output logic [31:0] pc_de,
  output logic [31:0] pc4_de,
  output logic        valid_de,
  output logic        fault_de
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_de_q, pc_de_d;
  logic [XLEN-1:0] pc4_de_q, pc4_de_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
`ifdef MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
`endif

  logic [XLEN-1:0] rom_data;
  logic            rom_in_range;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_fault;
  logic            bubble;

  imem_rom #(
    .IMEM_WORDS(IMEM_WORDS),
    .IMEM_INIT (IMEM_INIT)
  ) u_imem (
    .word_addr(pc_q[XLEN-1:2]),
    .rdata    (rom_data),
    .in_range (rom_in_range)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pc_de_d  = pc_de_q;
    pc4_de_d = pc4_de_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    bubble   = 1'b0;
    fetch_fault = !rom_in_range;
`ifdef MISALIGN_TRAP_EN
    misalign_d  = misalign_q;
    fetch_fault = !rom_in_range || misalign_q;
`endif

    if (br_taken) begin
      // Redirect beats stall: the wrong-path slot is squashed regardless of FSM state.
      pc_d    = {br_target[XLEN-1:2], 2'b00};
      bubble  = 1'b1;
      state_d = S_RUN;
`ifdef MISALIGN_TRAP_EN
      misalign_d = (br_target[1:0] != 2'b00);
`endif
    end else begin
      case (state_q)
        S_FILL: begin
          bubble  = 1'b1;
          state_d = S_RUN;
        end
        S_HALT: begin
          bubble = 1'b1;
        end
        default: begin
          if (stall_if) begin
            // hold everything; a concurrent flush is dropped
          end else if (flush_de) begin
            bubble = 1'b1;
            pc_d   = pc_plus4;
          end else begin
            inst_d   = fetch_fault ? RV_NOP : rom_data;
            pc_de_d  = pc_q;
            pc4_de_d = pc_plus4;
            valid_d  = 1'b1;
            fault_d  = fetch_fault;
            pc_d     = pc_plus4;
            if (fetch_fault) begin
              state_d = S_HALT;
            end
`ifdef MISALIGN_TRAP_EN
            misalign_d = 1'b0;
`endif
          end
        end
      endcase
    end

    if (bubble) begin
      inst_d   = RV_NOP;
      pc_de_d  = '0;
      pc4_de_d = '0;
      valid_d  = 1'b0;
      fault_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      pc_q     <= RESET_PC;
      inst_q   <= RV_NOP;
      pc_de_q  <= '0;
      pc4_de_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc_de_q  <= pc_de_d;
      pc4_de_q <= pc4_de_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign pc_if    = pc_q;
  assign inst_de  = inst_q;
  assign pc_de    = pc_de_q;
  assign pc4_de   = pc4_de_q;
  assign valid_de = valid_q;
  assign fault_de = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage with a 4-word image; expectations queued as each cycle's stimulus is driven.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0054_0413;
  localparam logic [31:0] I1  = 32'h0089_04b3;
  localparam logic [31:0] I2  = 32'h0139_09b3;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        v;
    logic        f;
    logic        chk_pc;
    logic [31:0] pc_de;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_if = 1'b0;
  logic        flush_de = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] pc_if, inst_de, pc_de, pc4_de;
  logic        valid_de, fault_de;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_step = 0;

  fetch_stage #(
    .IMEM_WORDS(4),
    .RESET_PC  (32'h0),
    .IMEM_INIT ({NOP, I2, I1, I0})
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall_if (stall_if),
    .flush_de (flush_de),
    .br_taken (br_taken),
    .br_target(br_target),
    .pc_if    (pc_if),
    .inst_de  (inst_de),
    .pc_de    (pc_de),
    .pc4_de   (pc4_de),
    .valid_de (valid_de),
    .fault_de (fault_de)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic st, input logic fl, input logic br,
                      input logic [31:0] tgt, input logic [31:0] e_pc, input logic [31:0] e_inst,
                      input logic e_v, input logic e_f, input logic cp,
                      input logic [31:0] e_pcde, input logic [31:0] e_pc4);
    exp_t e, g;
    @(negedge clk);
    rst_n     = rn;
    stall_if  = st;
    flush_de  = fl;
    br_taken  = br;
    br_target = tgt;
    n_step++;
    e.tag = $sformatf("s%0d", n_step);
    e.pc = e_pc; e.inst = e_inst; e.v = e_v; e.f = e_f;
    e.chk_pc = cp; e.pc_de = e_pcde; e.pc4 = e_pc4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      check({g.tag, ".pc_if"},   pc_if,   g.pc);
      check({g.tag, ".inst_de"}, inst_de, g.inst);
      check({g.tag, ".valid"},   {31'd0, valid_de}, {31'd0, g.v});
      check({g.tag, ".fault"},   {31'd0, fault_de}, {31'd0, g.f});
      if (g.chk_pc) begin
        check({g.tag, ".pc_de"},  pc_de,  g.pc_de);
        check({g.tag, ".pc4_de"}, pc4_de, g.pc4);
      end
    end
  endtask

  initial begin
    // reset for two cycles
    step(0,0,0,0,32'h0,  32'h0, NOP, 0,0, 1, 32'h0, 32'h0);
    step(0,0,0,0,32'h0,  32'h0, NOP, 0,0, 1, 32'h0, 32'h0);
    // fill then sequential fetch
    step(1,0,0,0,32'h0,  32'h0, NOP, 0,0, 0, 32'h0, 32'h0);
    step(1,0,0,0,32'h0,  32'h4, I0,  1,0, 1, 32'h0, 32'h4);
    step(1,0,0,0,32'h0,  32'h8, I1,  1,0, 1, 32'h4, 32'h8);
    // stall two cycles, then release
    step(1,1,0,0,32'h0,  32'h8, I1,  1,0, 1, 32'h4, 32'h8);
    step(1,1,0,0,32'h0,  32'h8, I1,  1,0, 1, 32'h4, 32'h8);
    step(1,0,0,0,32'h0,  32'hC, I2,  1,0, 1, 32'h8, 32'hC);
    // redirect to 0, then stall+redirect together
    step(1,0,0,1,32'h0,  32'h0, NOP, 0,0, 0, 32'h0, 32'h0);
    step(1,0,0,0,32'h0,  32'h4, I0,  1,0, 1, 32'h0, 32'h4);
    step(1,1,0,1,32'h8,  32'h8, NOP, 0,0, 0, 32'h0, 32'h0);
    step(1,0,0,0,32'h0,  32'hC, I2,  1,0, 1, 32'h8, 32'hC);
    // flush at pc_if=4, then flush+stall holds
    step(1,0,0,1,32'h4,  32'h4, NOP, 0,0, 0, 32'h0, 32'h0);
    step(1,0,1,0,32'h0,  32'h8, NOP, 0,0, 0, 32'h0, 32'h0);
    step(1,0,0,0,32'h0,  32'hC, I2,  1,0, 1, 32'h8, 32'hC);
    step(1,1,1,0,32'h0,  32'hC, I2,  1,0, 1, 32'h8, 32'hC);
    // run off the end of the 4-word image into halt
    step(1,0,0,0,32'h0,  32'h10, NOP, 1,0, 1, 32'hC,  32'h10);
    step(1,0,0,0,32'h0,  32'h14, NOP, 1,1, 1, 32'h10, 32'h14);
    step(1,0,0,0,32'h0,  32'h14, NOP, 0,0, 0, 32'h0,  32'h0);
    step(1,1,0,0,32'h0,  32'h14, NOP, 0,0, 0, 32'h0,  32'h0);
    step(1,0,1,0,32'h0,  32'h14, NOP, 0,0, 0, 32'h0,  32'h0);
    step(1,0,0,1,32'h4,  32'h4,  NOP, 0,0, 0, 32'h0,  32'h0);
    step(1,0,0,0,32'h0,  32'h8,  I1,  1,0, 1, 32'h4,  32'h8);
    // misaligned redirect
    step(1,0,0,1,32'h6,  32'h4,  NOP, 0,0, 0, 32'h0,  32'h0);
`ifdef MISALIGN_TRAP_EN
    step(1,0,0,0,32'h0,  32'h8,  NOP, 1,1, 1, 32'h4,  32'h8);
    step(1,0,0,0,32'h0,  32'h8,  NOP, 0,0, 0, 32'h0,  32'h0);
`else
    step(1,0,0,0,32'h0,  32'h8,  I1,  1,0, 1, 32'h4,  32'h8);
    step(1,0,0,0,32'h0,  32'hC,  I2,  1,0, 1, 32'h8,  32'hC);
`endif
    // reset asserted during stall+redirect wins
    step(0,1,0,1,32'h8,  32'h0,  NOP, 0,0, 1, 32'h0,  32'h0);
    step(1,0,0,0,32'h0,  32'h0,  NOP, 0,0, 0, 32'h0,  32'h0);
    step(1,0,0,0,32'h0,  32'h4,  I0,  1,0, 1, 32'h0,  32'h4);
    // PC wrap from the top of the address space
    step(1,0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 0,0, 0, 32'h0, 32'h0);
    step(1,0,0,0,32'h0,  32'h0,  NOP, 1,1, 1, 32'hFFFF_FFFC, 32'h0);
    step(1,0,0,0,32'h0,  32'h0,  NOP, 0,0, 0, 32'h0,  32'h0);
    step(1,0,0,1,32'h0,  32'h0,  NOP, 0,0, 0, 32'h0,  32'h0);
    step(1,0,0,0,32'h0,  32'h4,  I0,  1,0, 1, 32'h0,  32'h4);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
